// File: rtl/gen_param_loader_pkg.sv
// Shared constants, state encoding and sizing helpers for the parameter loader.
package gen_param_loader_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_N_INPUT     = 2;
  localparam int DEF_N_NEURON_L2 = 3;
  localparam int DEF_N_NEURON_L3 = 9;

  localparam int N_WL2   = DEF_N_INPUT * DEF_N_NEURON_L2;
  localparam int N_BL2   = DEF_N_NEURON_L2;
  localparam int N_WL3   = DEF_N_NEURON_L2 * DEF_N_NEURON_L3;
  localparam int N_BL3   = DEF_N_NEURON_L3;
  localparam int N_TOTAL = N_WL2 + N_BL2 + N_WL3 + N_BL3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // A single-entry segment still needs a one-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CNT_W = idx_width(max4(N_WL2, N_BL2, N_WL3, N_BL3));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_WL2 = 3'd1,
    LD_BL2 = 3'd2,
    LD_WL3 = 3'd3,
    LD_BL3 = 3'd4,
    COMMIT = 3'd5
  } state_t;

endpackage

// File: rtl/param_segment.sv
// One parameter segment: indexed shadow register file plus the active bank loaded on commit.
module param_segment
  import gen_param_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [idx_width(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         data,
  input  logic                     commit,
  output logic [DEPTH*WIDTH-1:0]   active
);

  localparam int IW = idx_width(DEPTH);

  logic [WIDTH-1:0] shadow [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) shadow[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (we && idx == IW'(k)) shadow[k] <= data;
      end
    end
  end

  // The active bank only ever changes as a whole, so consumers never see a mixed set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= '0;
    end else if (commit) begin
      for (int k = 0; k < DEPTH; k++) active[k*WIDTH +: WIDTH] <= shadow[k];
    end
  end

endmodule

// File: rtl/gen_param_loader.sv
// Deserialises a stream of parameter words into the 2-3-9 generator buses with atomic commit.
module gen_param_loader
  import gen_param_loader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_INPUT     = DEF_N_INPUT,
  parameter int N_NEURON_L2 = DEF_N_NEURON_L2,
  parameter int N_NEURON_L3 = DEF_N_NEURON_L3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      in_data,
  output logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]  w_L2,
  output logic [N_NEURON_L2*WIDTH-1:0]          b_L2,
  output logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3,
  output logic [N_NEURON_L3*WIDTH-1:0]          b_L3,
  output logic                                  params_valid,
  output logic                                  load_done,
  output logic                                  busy
);

  localparam int L_WL2 = N_INPUT * N_NEURON_L2;
  localparam int L_BL2 = N_NEURON_L2;
  localparam int L_WL3 = N_NEURON_L2 * N_NEURON_L3;
  localparam int L_BL3 = N_NEURON_L3;
  localparam int CW    = idx_width(max4(L_WL2, L_BL2, L_WL3, L_BL3));

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   seg_end;
  logic            accept;
  logic            seg_last;

  always_comb begin
    seg_end = '0;
    case (state)
      LD_WL2:  seg_end = CW'(L_WL2 - 1);
      LD_BL2:  seg_end = CW'(L_BL2 - 1);
      LD_WL3:  seg_end = CW'(L_WL3 - 1);
      LD_BL3:  seg_end = CW'(L_BL3 - 1);
      default: seg_end = '0;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign seg_last = (cnt == seg_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LD_WL2;
      LD_WL2:  if (accept && seg_last) state_nx = LD_BL2;
      LD_BL2:  if (accept && seg_last) state_nx = LD_WL3;
      LD_WL3:  if (accept && seg_last) state_nx = LD_BL3;
      LD_BL3:  if (accept && seg_last) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    load_done = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LD_WL2, LD_BL2, LD_WL3, LD_BL3: in_ready = 1'b1;
      COMMIT:                         load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= seg_last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           params_valid <= 1'b0;
    else if (load_done) params_valid <= 1'b1;
  end

  param_segment #(.WIDTH(WIDTH), .DEPTH(L_WL2)) u_seg_wl2 (
    .clk(clk), .rst(rst), .we(accept && state == LD_WL2),
    .idx(cnt[idx_width(L_WL2)-1:0]), .data(in_data), .commit(load_done), .active(w_L2)
  );

  param_segment #(.WIDTH(WIDTH), .DEPTH(L_BL2)) u_seg_bl2 (
    .clk(clk), .rst(rst), .we(accept && state == LD_BL2),
    .idx(cnt[idx_width(L_BL2)-1:0]), .data(in_data), .commit(load_done), .active(b_L2)
  );

  param_segment #(.WIDTH(WIDTH), .DEPTH(L_WL3)) u_seg_wl3 (
    .clk(clk), .rst(rst), .we(accept && state == LD_WL3),
    .idx(cnt[idx_width(L_WL3)-1:0]), .data(in_data), .commit(load_done), .active(w_L3)
  );

  param_segment #(.WIDTH(WIDTH), .DEPTH(L_BL3)) u_seg_bl3 (
    .clk(clk), .rst(rst), .we(accept && state == LD_BL3),
    .idx(cnt[idx_width(L_BL3)-1:0]), .data(in_data), .commit(load_done), .active(b_L3)
  );

endmodule
